// File: rtl/jtcontra_gfxrom_arb.sv
// Shares one SDRAM read slot between the two jtcontra_gfx ROM ports (round robin, one read in flight).
// Define JTCONTRA_GFXARB_PRIO_EN to make gfx1 always win a tie instead of alternating.
module jtcontra_gfxrom_arb #(
    parameter int AW   = 18,
    parameter int TOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rom1_cs,
    input  logic [AW-1:0] rom1_addr,
    output logic [15:0]   rom1_data,
    output logic          rom1_ok,
    input  logic          rom2_cs,
    input  logic [AW-1:0] rom2_addr,
    output logic [15:0]   rom2_data,
    output logic          rom2_ok,
    output logic          sdram_cs,
    output logic [AW:0]   sdram_addr,
    input  logic [15:0]   sdram_data,
    input  logic          sdram_ok,
    output logic          tout_err
);

    localparam logic [7:0] TOUT_W = 8'(TOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   sdram_cs_q, sdram_cs_d;
    logic [AW:0]            sdram_addr_q, sdram_addr_d;
    logic [1:0][AW-1:0]     lat_addr_q, lat_addr_d;
    logic [1:0][15:0]       data_q, data_d;
    logic [1:0]             valid_q, valid_d;
    logic                   last_grant_q, last_grant_d;
    logic [AW-1:0]          req_addr_q, req_addr_d;
    logic [7:0]             wdog_q, wdog_d;
    logic                   tout_err_q, tout_err_d;

    logic [1:0]             req_cs;
    logic [1:0][AW-1:0]     req_in;
    logic [1:0]             hit;
    logic [1:0]             ok;
    logic [1:0]             pend;
    logic                   grant_ch;
    logic                   cur_ch;

    assign req_cs    = {rom2_cs, rom1_cs};
    assign req_in[0] = rom1_addr;
    assign req_in[1] = rom2_addr;

    // A latched word only counts while the requester still presents the address it was read for.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            assign hit[gi]  = valid_q[gi] && (req_in[gi] == lat_addr_q[gi]);
            assign ok[gi]   = req_cs[gi] && hit[gi];
            assign pend[gi] = req_cs[gi] && !hit[gi];
        end
    endgenerate

    assign cur_ch = sdram_addr_q[AW];

    always_comb begin
        state_d      = state_q;
        sdram_cs_d   = sdram_cs_q;
        sdram_addr_d = sdram_addr_q;
        lat_addr_d   = lat_addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        wdog_d       = wdog_q;
        tout_err_d   = tout_err_q;
        grant_ch     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend != 2'b00) begin
                    if (pend == 2'b11) begin
`ifdef JTCONTRA_GFXARB_PRIO_EN
                        grant_ch = 1'b0;
`else
                        grant_ch = ~last_grant_q;
`endif
                    end else begin
                        grant_ch = pend[1];
                    end
                    sdram_addr_d = {grant_ch, req_in[grant_ch]};
                    req_addr_d   = req_in[grant_ch];
                    sdram_cs_d   = 1'b1;
                    last_grant_d = grant_ch;
                    wdog_d       = 8'd0;
                    state_d      = ST_SETTLE;
                end
            end
            // sdram_ok may still belong to the previous address here, so it is not looked at.
            ST_SETTLE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sdram_ok) begin
                    data_d[cur_ch]     = sdram_data;
                    lat_addr_d[cur_ch] = req_addr_q;
                    valid_d[cur_ch]    = 1'b1;
                    sdram_cs_d         = 1'b0;
                    state_d            = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_d == TOUT_W) begin
                        sdram_cs_d = 1'b0;
                        tout_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sdram_cs_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sdram_cs_q   <= 1'b0;
            sdram_addr_q <= '0;
            lat_addr_q   <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            last_grant_q <= 1'b1;
            req_addr_q   <= '0;
            wdog_q       <= '0;
            tout_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sdram_cs_q   <= sdram_cs_d;
            sdram_addr_q <= sdram_addr_d;
            lat_addr_q   <= lat_addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
            req_addr_q   <= req_addr_d;
            wdog_q       <= wdog_d;
            tout_err_q   <= tout_err_d;
        end
    end

    assign rom1_data  = data_q[0];
    assign rom2_data  = data_q[1];
    assign rom1_ok    = ok[0];
    assign rom2_ok    = ok[1];
    assign sdram_cs   = sdram_cs_q;
    assign sdram_addr = sdram_addr_q;
    assign tout_err   = tout_err_q;

endmodule
